uart_tx: RTL and testbench

//  UART transmitter, the transmit end of the UART link. Accepts one byte per

---
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Accepts one byte per handshake and serialises it as an
//   11-bit frame on serial_out: start(0), 8 data bits LSB first, even parity,
//   stop(1). The line idles high and every output is registered.
//
//   Parameters
//     CLKS_PER_BIT   clk cycles each serial bit is held (>= 2)
//
//   Ports
//     clk             in   single clock, rising edge
//     reset           in   synchronous, active-high reset
//     transmit_data   in   [7:0] byte to send, sampled on the accept cycle only
//     start_transmit  in   request strobe, accepted only while tx_ready = 1
//     tx_ready        out  1 = idle, a byte can be accepted this cycle
//     serial_out      out  UART line, idle high
//     tx_done         out  one-cycle pulse when the stop bit completes
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high, tx_ready = 1, waiting for start_transmit
//   START  | driving the start bit (0) for CLKS_PER_BIT cycles
//   DATA   | driving data_reg[bit_idx], bit_idx 0..7, LSB first
//   PARITY | driving the latched even-parity bit
//   STOP   | driving the stop bit (1); terminal count returns to IDLE
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] transmit_data,
  input  logic       start_transmit,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       data_reg, data_reg_n;
  logic             parity_reg, parity_reg_n;
  logic             serial_out_n;
  logic             tx_ready_n;
  logic             tx_done_n;

  logic             baud_tc;
  logic [2:0]       bit_idx_inc;

  assign baud_tc     = (baud_cnt == CNT_MAX);
  assign bit_idx_inc = bit_idx + 3'd1;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_reg   <= '0;
      parity_reg <= 1'b0;
      serial_out <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      data_reg   <= data_reg_n;
      parity_reg <= parity_reg_n;
      serial_out <= serial_out_n;
      tx_ready   <= tx_ready_n;
      tx_done    <= tx_done_n;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic. serial_out_n is the value the line
  // takes after the coming edge, so each bit is presented on the edge that
  // enters its state and held until the edge that leaves it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_idx_n    = bit_idx;
    data_reg_n   = data_reg;
    parity_reg_n = parity_reg;
    serial_out_n = serial_out;
    tx_ready_n   = tx_ready;
    tx_done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        serial_out_n = 1'b1;
        tx_ready_n   = 1'b1;
        baud_cnt_n   = '0;
        bit_idx_n    = '0;
        if (tx_ready && start_transmit) begin
          data_reg_n   = transmit_data;
          parity_reg_n = ^transmit_data;
          state_n      = START;
          tx_ready_n   = 1'b0;
          serial_out_n = 1'b0;
        end
      end

      START: begin
        if (baud_tc) begin
          baud_cnt_n   = '0;
          bit_idx_n    = '0;
          state_n      = DATA;
          serial_out_n = data_reg[0];
        end else begin
          baud_cnt_n   = baud_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_tc) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n    = '0;
            state_n      = PARITY;
            serial_out_n = parity_reg;
          end else begin
            bit_idx_n    = bit_idx_inc;
            serial_out_n = data_reg[bit_idx_inc];
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      PARITY: begin
        if (baud_tc) begin
          baud_cnt_n   = '0;
          state_n      = STOP;
          serial_out_n = 1'b1;
        end else begin
          baud_cnt_n   = baud_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        serial_out_n = 1'b1;
        if (baud_tc) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
          tx_ready_n = 1'b1;
          tx_done_n  = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_n      = IDLE;
        baud_cnt_n   = '0;
        bit_idx_n    = '0;
        serial_out_n = 1'b1;
        tx_ready_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed and random frames for uart_tx with CLKS_PER_BIT = 4. Expected
//   line levels come from the frame format (start, data LSB first, even
//   parity, stop), and a behavioural mid-bit sampling receiver decodes the
//   line for the loopback frames.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] transmit_data = 8'h00;
  logic       start_transmit = 1'b0;
  logic       tx_ready;
  logic       serial_out;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  bit         rx_err_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .transmit_data  (transmit_data),
    .start_transmit (start_transmit),
    .tx_ready       (tx_ready),
    .serial_out     (serial_out),
    .tx_done        (tx_done)
  );

  // Level of frame bit k (0..10) for byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line stays idle: {serial_out, tx_ready, tx_done} = 110 every cycle.
  task automatic idle_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s_idle%0d", tag, i), 32'({serial_out, tx_ready, tx_done}), 32'h6);
    end
  endtask

  // Requests byte b at the next edge and checks every cycle of the frame.
  // Returns at the negedge after the stop bit completes (tx_done high).
  task automatic send_frame(input logic [7:0] b, input bit hold, input int pulse_at,
                            input logic [7:0] pulse_b, input string tag);
    chk({tag, "_ready_pre"}, 32'(tx_ready), 32'h1);
    transmit_data  = b;
    start_transmit = 1'b1;
    @(negedge clk);
    if (!hold) start_transmit = 1'b0;
    for (int i = 0; i < 11*N; i++) begin
      chk($sformatf("%s_c%0d", tag, i), 32'({serial_out, tx_ready, tx_done}),
          32'({exp_bit(b, i / N), 2'b00}));
      if (i == pulse_at) begin
        start_transmit = 1'b1;
        transmit_data  = pulse_b;
      end else begin
        if (!hold) start_transmit = 1'b0;
        transmit_data = 8'($urandom);
      end
      @(negedge clk);
    end
    chk({tag, "_end"}, 32'({serial_out, tx_ready, tx_done}), 32'h7);
  endtask

  // Behavioural receiver: finds the start bit and samples mid-bit.
  initial begin : rx_model
    logic [10:0] f;
    forever begin
      @(negedge clk);
      if (!reset && serial_out === 1'b0) begin
        repeat (N/2) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
          f[k] = serial_out;
          if (k < 10) repeat (N) @(negedge clk);
        end
        rx_q.push_back(f[8:1]);
        rx_err_q.push_back(f[0] !== 1'b0 || f[10] !== 1'b1 || (^f[9:1]) !== 1'b0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    int         gap;

    // Reset state
    reset = 1'b1;
    start_transmit = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({serial_out, tx_ready, tx_done}), 32'h6);
    reset = 1'b0;
    start_transmit = 1'b0;
    idle_check(3, "post_reset");

    // 1: 0xA5 frame, tx_done 44 clk after accept
    send_frame(8'hA5, 1'b0, -1, 8'h00, "t1_a5");
    idle_check(3, "t1");

    // 2: parity cases
    send_frame(8'h07, 1'b0, -1, 8'h00, "t2_07");
    idle_check(2, "t2a");
    send_frame(8'h00, 1'b0, -1, 8'h00, "t2_00");
    idle_check(2, "t2b");
    send_frame(8'hFF, 1'b0, -1, 8'h00, "t2_ff");
    idle_check(2, "t2c");

    // 3: back-to-back with start_transmit held high
    send_frame(8'h3C, 1'b1, -1, 8'h00, "t3_3c");
    send_frame(8'hC3, 1'b1, -1, 8'h00, "t3_c3");
    start_transmit = 1'b0;
    idle_check(12*N, "t3");

    // 4: mid-frame request is ignored, not queued
    send_frame(8'h81, 1'b0, 10, 8'h55, "t4_81");
    idle_check(12*N, "t4");

    // 5: reset during data bit 3
    transmit_data  = 8'hF0;
    start_transmit = 1'b1;
    @(negedge clk);
    start_transmit = 1'b0;
    repeat (4*N + 1) @(negedge clk);
    chk("t5_in_bit3", 32'(serial_out), 32'(exp_bit(8'hF0, 4)));
    reset = 1'b1;
    start_transmit = 1'b1;
    @(negedge clk);
    chk("t5_reset_edge", 32'({serial_out, tx_ready, tx_done}), 32'h6);
    @(negedge clk);
    chk("t5_reset_hold", 32'({serial_out, tx_ready, tx_done}), 32'h6);
    reset = 1'b0;
    start_transmit = 1'b0;
    idle_check(12*N, "t5_abandon");
    send_frame(8'h12, 1'b0, -1, 8'h00, "t5_12");
    idle_check(15*N, "t5");

    // 6: random bytes through the receiver model
    rx_q.delete();
    rx_err_q.delete();
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, -1, 8'h00, $sformatf("t6_f%0d", n));
      chk($sformatf("t6_rx_count%0d", n), 32'(rx_q.size()), 32'h1);
      if (rx_q.size() > 0) begin
        chk($sformatf("t6_rx_data%0d", n), 32'(rx_q.pop_front()), 32'(b));
        chk($sformatf("t6_rx_err%0d", n), 32'(rx_err_q.pop_front()), 32'h0);
      end
      gap = $urandom_range(0, 3);
      idle_check(gap, $sformatf("t6_g%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
